sba_ctrl: RTL
=============

SBA_CTRL -- requirements
Module: sba_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, bus cycles allowed per access before abort.
REQ-002 Ports, one per line (name, direction, width, meaning); one clock, reset asynchronous and active-high:
  clk  in  1  clock
  rst  in  1  asynchronous active-high reset
  sba_clr  in  1  synchronous clear, pulsed when the debug module is deactivated (dmactive=0)
  reg_wr  in  1  one-cycle DMI write strobe
  reg_rd  in  1  one-cycle DMI read strobe
  reg_addr  in  7  DMI register address: 0x38 sbcs, 0x39 sbaddress0, 0x3C sbdata0
  reg_wdata  in  32  DMI write data
  reg_rdata  out  32  combinational read data for reg_addr; 0 for other addresses
  bus_req  out  1  access request
  bus_we  out  1  write access
  bus_addr  out  32  byte address
  bus_be  out  4  byte enables
  bus_wdata  out  32  write data
  bus_ack  in  1  one-cycle completion
  bus_rdata  in  32  read data, valid with bus_ack
  bus_err  in  1  error, valid with bus_ack

Function
REQ-003 sbcs readback: sbversion[31:29]=1; sbbusyerror[22]; sbbusy[21]; sbreadonaddr[20]; sbaccess[19:17]; sbautoincrement[16]; sbreadondata[15]; sberror[14:12]; sbasize[11:5]=32; access-size bits[4:0]=5'b00111.
REQ-004 sbcs write: sbreadonaddr, sbaccess, sbautoincrement and sbreadondata load from reg_wdata; sbbusyerror and sberror are write-1-to-clear; all other bits ignored.
REQ-005 The FSM SHALL have three states: IDLE, REQ and DONE. sbbusy=1 in REQ and DONE.
REQ-006 Transitions:
  IDLE->REQ on a start; bus_req rises the next cycle.
  REQ->DONE on bus_ack; bus_req and bus_addr/bus_we/bus_be/bus_wdata stay stable until then.
  DONE->IDLE after one cycle, in which sbdata0, sberror and sbaddress0 update.
REQ-007 Write sbaddress0 while not busy: load; if sbreadonaddr=1, start a read.
REQ-008 Write sbdata0 while not busy: load; start a write.
REQ-009 Read sbdata0 while not busy: reg_rdata returns the current sbdata0; if sbreadondata=1, start a read.
REQ-010 No start while sberror!=0 or sbbusyerror=1; the register update in REQ-007/008 still occurs.
REQ-011 Access to sbaddress0 or sbdata0 (write, or read of sbdata0) while sbbusy=1: set sbbusyerror, no register change, no new access. This includes the cycle bus_ack arrives.
REQ-012 Start checks, in priority order, each blocking the access:
  sbaccess>2 -> sberror=4
  address misaligned for size -> sberror=3
REQ-013 bus_ack with bus_err=1 -> sberror=2; sbdata0 and sbaddress0 unchanged.
REQ-014 Write lanes: sbaccess 0/1/2 gives bus_be 4'b0001<<a[1:0] / 4'b0011<<a[1:0] / 4'b1111; bus_wdata replicates the low byte/halfword across lanes.
REQ-015 Read lanes: selected lane right-shifted into sbdata0, zero-extended.
REQ-016 After a successful access with sbautoincrement=1, sbaddress0 += (1<<sbaccess), modulo 2^32 (0xFFFFFFFC+4 wraps to 0).
REQ-017 sba_clr: return to IDLE, drop bus_req the same cycle, clear all registers to reset values.

Reset
REQ-018 On rst: FSM=IDLE; bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0; sbaddress0=0, sbdata0=0.
REQ-019 On rst: sbcs writable and sticky fields are 0 except sbaccess=2. An in-flight access is abandoned, bus_req falls asynchronously, and a late bus_ack is ignored.

Configuration
REQ-020 Macro SBA_TIMEOUT_EN.
  Defined: a counter runs in REQ; reaching TIMEOUT_CYCLES drops bus_req, sets sberror=1 and moves to DONE.
  Undefined: no counter; REQ waits indefinitely for bus_ack.

Structure
REQ-021 sbcs_t packed struct, state enum and sberror codes live in the shared debug package `instructions`.
REQ-022 Lane steering (REQ-014/015) SHALL be the sub-module sba_lanes, purely combinational.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  Word read: sbcs=0x00140000, write sbaddress0=0x100, bus_rdata=0xDEADBEEF -> bus_req next cycle, sbdata0=0xDEADBEEF, sbaddress0=0x100.
  Byte write with autoincrement: sbcs sbaccess=0, sbautoincrement=1; sbaddress0=0x103; sbdata0=0xA5 -> bus_be=4'b1000, bus_wdata=0xA5A5A5A5, sbaddress0=0x104.
  Misaligned halfword at 0x101 -> no bus_req, sberror=3; write-1-clear of sbcs[14:12] -> sberror=0.
  Busy collision: write sbdata0 while bus_ack withheld -> sbbusyerror=1, the following access blocked until cleared.
  bus_err on ack -> sberror=2; with SBA_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> sberror=1 after 8 cycles.
  rst asserted mid-REQ -> bus_req=0 immediately; a subsequent bus_ack does not change sbdata0.

Source files
------------

// File: rtl/instructions.sv
// Shared debug package: system bus access (SBA) state machine encoding,
// sberror codes, the sbcs register layout and DMI register addresses.
package instructions;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } sba_state_e;

  typedef enum logic [2:0] {
    SBERR_NONE    = 3'd0,
    SBERR_TIMEOUT = 3'd1,
    SBERR_BADADDR = 3'd2,
    SBERR_ALIGN   = 3'd3,
    SBERR_SIZE    = 3'd4,
    SBERR_OTHER   = 3'd7
  } sberror_e;

  typedef struct packed {
    logic [2:0] sbversion;
    logic [5:0] zero0;
    logic       sbbusyerror;
    logic       sbbusy;
    logic       sbreadonaddr;
    logic [2:0] sbaccess;
    logic       sbautoincrement;
    logic       sbreadondata;
    logic [2:0] sberror;
    logic [6:0] sbasize;
    logic [4:0] sbaccess_sizes;
  } sbcs_t;

  localparam logic [6:0] ADDR_SBCS       = 7'h38;
  localparam logic [6:0] ADDR_SBADDRESS0 = 7'h39;
  localparam logic [6:0] ADDR_SBDATA0    = 7'h3C;

  localparam logic [2:0] SBACCESS_RESET  = 3'd2;

  // True when the byte address is not naturally aligned for the access size.
  function automatic logic misaligned(input logic [2:0] acc, input logic [1:0] a);
    case (acc)
      3'd1:    return a[0];
      3'd2:    return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sba_lanes.sv
// Byte-lane steering for system bus accesses: byte enables and write data
// replication on the way out, lane extraction and zero-extension on the way in.
module sba_lanes (
  input  logic [2:0]  access,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [31:0] shifted;

  // Select lanes by access size; word is the fallback for any other size.
  always_comb begin
    shifted   = rdata_in >> {addr_lo, 3'b000};
    be        = 4'b1111;
    wdata_out = wdata_in;
    rdata_out = rdata_in;
    case (access)
      3'd0: begin
        be        = 4'b0001 << addr_lo;
        wdata_out = {4{wdata_in[7:0]}};
        rdata_out = {24'b0, shifted[7:0]};
      end
      3'd1: begin
        be        = 4'b0011 << addr_lo;
        wdata_out = {2{wdata_in[15:0]}};
        rdata_out = {16'b0, shifted[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata_out = wdata_in;
        rdata_out = rdata_in;
      end
    endcase
  end

endmodule

// File: rtl/sba_ctrl.sv
// System bus access controller for a RISC-V debug module: sbcs / sbaddress0 /
// sbdata0 registers on the DMI side, a single-outstanding request/ack bus on
// the other. Bus handshake: bus_req and the address/data/enable outputs are
// held stable from the cycle after a start until the cycle bus_ack is seen;
// bus_ack is a one-cycle pulse carrying bus_rdata and bus_err.
// Build option: define SBA_TIMEOUT_EN to abort accesses that see no bus_ack
// within TIMEOUT_CYCLES cycles (sberror=1).
module sba_ctrl
  import instructions::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sba_clr,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [6:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  sba_state_e  state;
  logic        bus_req_q;
  logic [2:0]  acc_q;
  logic [31:0] rdata_q;
  sberror_e    err_q;

  logic        busyerror, readonaddr, autoinc, readondata;
  logic [2:0]  sbaccess, sberror;
  logic [31:0] sbaddress0, sbdata0;

  logic        wr_sbcs, wr_addr, wr_data, rd_data;
  logic        busy, blocked, start_rd, start_wr, start_req;
  logic        size_err, align_err, go;
  logic [31:0] start_addr;
  logic [2:0]  lane_access;
  logic [1:0]  lane_addr;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;
  logic        tmo_hit;
  sbcs_t       sbcs_view;

  // DMI decode and start qualification.
  always_comb begin
    wr_sbcs    = reg_wr && (reg_addr == ADDR_SBCS);
    wr_addr    = reg_wr && (reg_addr == ADDR_SBADDRESS0);
    wr_data    = reg_wr && (reg_addr == ADDR_SBDATA0);
    rd_data    = reg_rd && (reg_addr == ADDR_SBDATA0);
    busy       = (state != ST_IDLE);
    blocked    = (sberror != 3'd0) || busyerror;
    start_rd   = !busy && !blocked && ((wr_addr && readonaddr) || (rd_data && readondata));
    start_wr   = !busy && !blocked && wr_data;
    start_req  = start_rd || start_wr;
    start_addr = wr_addr ? reg_wdata : sbaddress0;
    size_err   = (sbaccess > 3'd2);
    align_err  = misaligned(sbaccess, start_addr[1:0]);
    go         = start_req && !size_err && !align_err;
    // Idle: steer for the access being started; busy: for the one in flight.
    lane_access = busy ? acc_q : sbaccess;
    lane_addr   = busy ? bus_addr[1:0] : start_addr[1:0];
  end

  sba_lanes u_lanes (
    .access    (lane_access),
    .addr_lo   (lane_addr),
    .wdata_in  (reg_wdata),
    .rdata_in  (rdata_q),
    .be        (lane_be),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata)
  );

  // A clear pulse must take bus_req down in the cycle it is seen.
  assign bus_req = bus_req_q && !sba_clr;

`ifdef SBA_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Count cycles spent waiting in REQ; restarts on every new access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state != ST_REQ) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state == ST_REQ) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  // The limit only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // Access FSM and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bus_req_q <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      acc_q     <= SBACCESS_RESET;
      rdata_q   <= '0;
      err_q     <= SBERR_NONE;
    end else if (sba_clr) begin
      state     <= ST_IDLE;
      bus_req_q <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      acc_q     <= SBACCESS_RESET;
      rdata_q   <= '0;
      err_q     <= SBERR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            state     <= ST_REQ;
            bus_req_q <= 1'b1;
            bus_we    <= start_wr;
            bus_addr  <= start_addr;
            bus_be    <= lane_be;
            bus_wdata <= start_wr ? lane_wdata : 32'h0;
            acc_q     <= sbaccess;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            state     <= ST_DONE;
            bus_req_q <= 1'b0;
            rdata_q   <= bus_rdata;
            err_q     <= bus_err ? SBERR_BADADDR : SBERR_NONE;
          end else if (tmo_hit) begin
            state     <= ST_DONE;
            bus_req_q <= 1'b0;
            err_q     <= SBERR_TIMEOUT;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Register file: DMI writes, start-check errors, busy collisions and
  // the completion update in DONE (which wins over a same-cycle sbcs clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busyerror  <= 1'b0;
      readonaddr <= 1'b0;
      sbaccess   <= SBACCESS_RESET;
      autoinc    <= 1'b0;
      readondata <= 1'b0;
      sberror    <= 3'd0;
      sbaddress0 <= '0;
      sbdata0    <= '0;
    end else if (sba_clr) begin
      busyerror  <= 1'b0;
      readonaddr <= 1'b0;
      sbaccess   <= SBACCESS_RESET;
      autoinc    <= 1'b0;
      readondata <= 1'b0;
      sberror    <= 3'd0;
      sbaddress0 <= '0;
      sbdata0    <= '0;
    end else begin
      if (wr_sbcs) begin
        readonaddr <= reg_wdata[20];
        sbaccess   <= reg_wdata[19:17];
        autoinc    <= reg_wdata[16];
        readondata <= reg_wdata[15];
        if (reg_wdata[22]) busyerror <= 1'b0;
        sberror    <= sberror & ~reg_wdata[14:12];
      end
      if (busy) begin
        if (wr_addr || wr_data || rd_data) busyerror <= 1'b1;
      end else begin
        if (wr_addr) sbaddress0 <= reg_wdata;
        if (wr_data) sbdata0    <= reg_wdata;
        if (start_req && size_err)       sberror <= SBERR_SIZE;
        else if (start_req && align_err) sberror <= SBERR_ALIGN;
      end
      if (state == ST_DONE) begin
        if (err_q != SBERR_NONE) begin
          sberror <= err_q;
        end else begin
          if (!bus_we) sbdata0 <= lane_rdata;
          if (autoinc) sbaddress0 <= sbaddress0 + (32'd1 << acc_q);
        end
      end
    end
  end

  // Combinational DMI readback.
  always_comb begin
    sbcs_view                 = '0;
    sbcs_view.sbversion       = 3'd1;
    sbcs_view.sbbusyerror     = busyerror;
    sbcs_view.sbbusy          = busy;
    sbcs_view.sbreadonaddr    = readonaddr;
    sbcs_view.sbaccess        = sbaccess;
    sbcs_view.sbautoincrement = autoinc;
    sbcs_view.sbreadondata    = readondata;
    sbcs_view.sberror         = sberror;
    sbcs_view.sbasize         = 7'd32;
    sbcs_view.sbaccess_sizes  = 5'b00111;
    case (reg_addr)
      ADDR_SBCS:       reg_rdata = sbcs_view;
      ADDR_SBADDRESS0: reg_rdata = sbaddress0;
      ADDR_SBDATA0:    reg_rdata = sbdata0;
      default:         reg_rdata = 32'h0;
    endcase
  end

endmodule
